// File: rtl/note_change_arbiter_pkg.sv
// Shared types for the note-change arbiter: message struct, source tag, FSM states, FIFO depth.
package note_change_arbiter_pkg;

    localparam int NOTE_ARB_FIFO_DEPTH = 4;

    typedef enum logic {
        MSG_NOTE_OFF = 1'b0,
        MSG_NOTE_ON  = 1'b1
    } note_msg_e;

    typedef struct packed {
        note_msg_e  msg;
        logic [6:0] note;
        logic [6:0] velocity;
    } note_change_t;

    typedef enum logic {
        LIVE   = 1'b0,
        REPLAY = 1'b1
    } note_src_e;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } arb_state_e;

    // A NOTE_ON with velocity 0 is a release, as in MIDI running-status practice.
    function automatic logic note_sounds(input note_change_t c);
        return (c.msg == MSG_NOTE_ON) && (c.velocity != 7'd0);
    endfunction

endpackage

// File: rtl/note_fifo.sv
// Parametric synchronous FIFO; a pop on the same edge frees room for a push into a full FIFO.
module note_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 15
) (
    input  logic             clk_sys,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_dout
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CW'(DEPTH));
    assign o_dout    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty && !i_clear;
    assign w_do_push = i_push && !i_clear && (!o_full || w_do_pop);

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    always_ff @(posedge clk_sys) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_din;
    end

endmodule

// File: rtl/note_change_arbiter.sv
// Round-robin merge of live and replay note changes into one output register.
// Optional panic flush of all sounding notes when NOTE_ARB_PANIC_EN is defined.
//   state    | meaning
//   ST_RUN   | normal round-robin service of both FIFOs
//   ST_FLUSH | scanning the active bitmap, emitting NOTE_OFF per sounding note
module note_change_arbiter
    import note_change_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH = NOTE_ARB_FIFO_DEPTH
) (
    input  logic         clock_50_000_000,
    input  logic         reset,
    input  note_change_t live,
    input  logic         live_ready,
    input  note_change_t replay,
    input  logic         replay_ready,
    input  logic         panic,
    output note_change_t note_out,
    output logic         note_out_valid,
    input  logic         note_out_ready,
    output logic [1:0]   overflow,
    output logic         busy
);
    note_change_t r_note_out;
    logic         r_valid;
    logic [1:0]   r_overflow;
    note_src_e    r_last_grant;
    note_src_e    w_grant;
    note_change_t w_live_dout, w_rep_dout, w_pop_data, w_flush_note;
    logic         w_live_full, w_live_empty, w_rep_full, w_rep_empty;
    logic         w_load, w_pop_en, w_pop_live, w_pop_rep, w_block_in;
    logic         w_flushing, w_panic_go, w_flush_emit;

    assign w_load     = !r_valid || note_out_ready;
    assign w_block_in = w_flushing || w_panic_go;

    always_comb begin
        w_grant = REPLAY;
        if (!w_live_empty && !w_rep_empty)
            w_grant = (r_last_grant == LIVE) ? REPLAY : LIVE;
        else if (!w_live_empty)
            w_grant = LIVE;
    end

    assign w_pop_en   = w_load && !w_block_in && (!w_live_empty || !w_rep_empty);
    assign w_pop_live = w_pop_en && (w_grant == LIVE);
    assign w_pop_rep  = w_pop_en && (w_grant == REPLAY);
    assign w_pop_data = (w_grant == LIVE) ? w_live_dout : w_rep_dout;

    note_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH($bits(note_change_t))) u_live_fifo (
        .clk_sys(clock_50_000_000), .rst(reset), .i_clear(w_panic_go),
        .i_push(live_ready && !w_block_in), .i_din(live), .i_pop(w_pop_live),
        .o_full(w_live_full), .o_empty(w_live_empty), .o_dout(w_live_dout)
    );

    note_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH($bits(note_change_t))) u_replay_fifo (
        .clk_sys(clock_50_000_000), .rst(reset), .i_clear(w_panic_go),
        .i_push(replay_ready && !w_block_in), .i_din(replay), .i_pop(w_pop_rep),
        .o_full(w_rep_full), .o_empty(w_rep_empty), .o_dout(w_rep_dout)
    );

    // A drop only happens when the FIFO stays full across this edge.
    always_ff @(posedge clock_50_000_000 or posedge reset) begin
        if (reset) begin
            r_overflow <= '0;
        end else begin
            if (live_ready && !w_block_in && w_live_full && !w_pop_live) r_overflow[0] <= 1'b1;
            if (replay_ready && !w_block_in && w_rep_full && !w_pop_rep) r_overflow[1] <= 1'b1;
        end
    end

    always_ff @(posedge clock_50_000_000 or posedge reset) begin
        if (reset) begin
            r_note_out   <= '0;
            r_valid      <= 1'b0;
            r_last_grant <= REPLAY;
        end else if (w_load) begin
            if (w_pop_en) begin
                r_note_out   <= w_pop_data;
                r_valid      <= 1'b1;
                r_last_grant <= w_grant;
            end else if (w_flush_emit) begin
                r_note_out <= w_flush_note;
                r_valid    <= 1'b1;
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

`ifdef NOTE_ARB_PANIC_EN
    arb_state_e   r_state, w_state_nxt;
    logic [6:0]   r_idx;
    logic [127:0] r_bitmap;

    always_ff @(posedge clock_50_000_000 or posedge reset) begin
        if (reset) r_state <= ST_RUN;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:   if (panic) w_state_nxt = ST_FLUSH;
            ST_FLUSH: if (w_load && (r_idx == 7'd127)) w_state_nxt = ST_RUN;
            default:  w_state_nxt = ST_RUN;
        endcase
    end

    always_comb begin
        w_flushing   = (r_state == ST_FLUSH);
        w_panic_go   = (r_state == ST_RUN) && panic;
        w_flush_emit = w_flushing && w_load && r_bitmap[r_idx];
        w_flush_note = '{msg: MSG_NOTE_OFF, note: r_idx, velocity: 7'd0};
    end

    // The scan index wraps to 0 after 127, ready for the next panic.
    always_ff @(posedge clock_50_000_000 or posedge reset) begin
        if (reset) begin
            r_idx    <= '0;
            r_bitmap <= '0;
        end else begin
            if (w_flushing && w_load) r_idx <= r_idx + 7'd1;
            if (r_valid && note_out_ready) r_bitmap[r_note_out.note] <= note_sounds(r_note_out);
        end
    end
`else
    logic w_unused_panic;
    assign w_unused_panic = panic;
    assign w_flushing     = 1'b0;
    assign w_panic_go     = 1'b0;
    assign w_flush_emit   = 1'b0;
    assign w_flush_note   = '0;
`endif

    assign note_out       = r_note_out;
    assign note_out_valid = r_valid;
    assign overflow       = r_overflow;
    assign busy           = !w_live_empty || !w_rep_empty || r_valid || w_flushing;

endmodule

// File: tb/tb_note_change_arbiter.sv
// Self-checking bench for note_change_arbiter against a queue-based reference model.
module tb_note_change_arbiter;
    import note_change_arbiter_pkg::*;

    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst;
    note_change_t live, replay, note_out;
    logic         live_ready, replay_ready, panic;
    logic         note_out_valid, note_out_ready, busy;
    logic [1:0]   overflow;

    int errors = 0;
    int checks = 0;

    note_change_t m_q_live[$], m_q_rep[$];
    note_change_t m_out;
    bit           m_valid;
    bit           m_last_rep;
    bit [1:0]     m_ovf;
    bit           m_flush;
    int           m_idx;
    bit           m_bm[128];
    note_change_t dut_acc[$], m_acc[$];

    always #10 clk = ~clk;

    note_change_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
        .clock_50_000_000(clk), .reset(rst),
        .live(live), .live_ready(live_ready),
        .replay(replay), .replay_ready(replay_ready),
        .panic(panic),
        .note_out(note_out), .note_out_valid(note_out_valid), .note_out_ready(note_out_ready),
        .overflow(overflow), .busy(busy)
    );

    function automatic note_change_t mk(input bit on, input int n, input int v);
        note_change_t c;
        c.msg      = on ? MSG_NOTE_ON : MSG_NOTE_OFF;
        c.note     = 7'(n);
        c.velocity = 7'(v);
        return c;
    endfunction

    function automatic bit model_busy();
        return (m_q_live.size() > 0) || (m_q_rep.size() > 0) || m_valid || m_flush;
    endfunction

    task automatic model_reset();
        m_q_live.delete();
        m_q_rep.delete();
        m_out      = '0;
        m_valid    = 1'b0;
        m_last_rep = 1'b1;
        m_ovf      = 2'b00;
        m_flush    = 1'b0;
        m_idx      = 0;
        for (int i = 0; i < 128; i++) m_bm[i] = 1'b0;
    endtask

    task automatic model_run(input bit load);
        if (load) begin
            if (m_q_live.size() > 0 && (m_q_rep.size() == 0 || m_last_rep)) begin
                m_out = m_q_live.pop_front(); m_valid = 1'b1; m_last_rep = 1'b0;
            end else if (m_q_rep.size() > 0) begin
                m_out = m_q_rep.pop_front(); m_valid = 1'b1; m_last_rep = 1'b1;
            end else begin
                m_valid = 1'b0;
            end
        end
        if (live_ready) begin
            if (m_q_live.size() < DEPTH) m_q_live.push_back(live);
            else m_ovf[0] = 1'b1;
        end
        if (replay_ready) begin
            if (m_q_rep.size() < DEPTH) m_q_rep.push_back(replay);
            else m_ovf[1] = 1'b1;
        end
    endtask

    task automatic model_edge();
        bit acc, load;
        note_change_t acc_c;
        if (rst) begin
            model_reset();
            return;
        end
        acc   = m_valid && note_out_ready;
        load  = !m_valid || note_out_ready;
        acc_c = m_out;
        if (acc) m_acc.push_back(acc_c);
`ifdef NOTE_ARB_PANIC_EN
        if (m_flush) begin
            if (load) begin
                if (m_bm[m_idx]) begin
                    m_out = mk(1'b0, m_idx, 0); m_valid = 1'b1;
                end else begin
                    m_valid = 1'b0;
                end
                if (m_idx == 127) m_flush = 1'b0;
                m_idx = (m_idx + 1) % 128;
            end
        end else if (panic) begin
            m_q_live.delete();
            m_q_rep.delete();
            if (load) m_valid = 1'b0;
            m_flush = 1'b1;
            m_idx   = 0;
        end else begin
            model_run(load);
        end
        if (acc) m_bm[acc_c.note] = (acc_c.msg == MSG_NOTE_ON) && (acc_c.velocity != 0);
`else
        model_run(load);
`endif
    endtask

    task automatic tick();
        if (note_out_valid && note_out_ready) dut_acc.push_back(note_out);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        live_ready = 1'b0; replay_ready = 1'b0; panic = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        idle_inputs();
        tick(); tick();
        rst = 1'b0;
        dut_acc.delete();
        m_acc.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; idle_inputs(); note_out_ready = 1'b1;
        live = '0; replay = '0;
        model_reset();
        tick(); tick();
        checks++; if (note_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", note_out_valid); end
        checks++; if (note_out !== '0) begin errors++; $display("FAIL reset_note_out: got %0h want 0", note_out); end
        checks++; if (overflow !== 2'b00) begin errors++; $display("FAIL reset_overflow: got %0b want 00", overflow); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
        rst = 1'b0;
    endtask

    task automatic test_latency();
        apply_reset();
        note_out_ready = 1'b1;
        live = mk(1'b1, 60, 127); live_ready = 1'b1;
        tick();
        live_ready = 1'b0;
        checks++; if (note_out_valid !== 1'b0) begin errors++; $display("FAIL latency_edgeN: valid=%0b want 0", note_out_valid); end
        tick();
        checks++; if (note_out_valid !== 1'b1) begin errors++; $display("FAIL latency_edgeN1: valid=%0b want 1", note_out_valid); end
        checks++; if (note_out !== mk(1'b1, 60, 127)) begin errors++; $display("FAIL latency_note: got %0h want %0h", note_out, mk(1'b1, 60, 127)); end
        tick();
        checks++; if (note_out_valid !== 1'b0) begin errors++; $display("FAIL latency_one_cycle: valid=%0b want 0", note_out_valid); end
    endtask

    task automatic test_round_robin();
        int exp_notes[5] = '{1, 2, 3, 2, 1};
        apply_reset();
        note_out_ready = 1'b1;
        live = mk(1'b1, 1, 100); replay = mk(1'b1, 2, 100);
        live_ready = 1'b1; replay_ready = 1'b1;
        tick(); idle_inputs(); tick(); tick(); tick();
        live = mk(1'b1, 3, 100); live_ready = 1'b1;
        tick(); idle_inputs(); tick(); tick(); tick();
        live = mk(1'b1, 1, 100); replay = mk(1'b1, 2, 100);
        live_ready = 1'b1; replay_ready = 1'b1;
        tick(); idle_inputs();
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (dut_acc.size() != 5) begin
            errors++; $display("FAIL rr_count: got %0d want 5", dut_acc.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (dut_acc[i].note !== 7'(exp_notes[i])) begin
                    errors++; $display("FAIL rr_order[%0d]: got %0d want %0d", i, dut_acc[i].note, exp_notes[i]);
                end
            end
        end
    endtask

    task automatic test_overflow();
        apply_reset();
        note_out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            live = mk(1'b1, 30 + i, 64); live_ready = 1'b1;
            tick();
        end
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (note_out_valid !== 1'b1 || note_out !== mk(1'b1, 30, 64)) begin
                errors++; $display("FAIL ovf_hold[%0d]: got v=%0b %0h want v=1 %0h", i, note_out_valid, note_out, mk(1'b1, 30, 64));
            end
        end
        checks++; if (overflow !== 2'b01) begin errors++; $display("FAIL ovf_flag: got %0b want 01", overflow); end
        note_out_ready = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if (dut_acc.size() != 5) begin
            errors++; $display("FAIL ovf_drain_count: got %0d want 5", dut_acc.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (dut_acc[i] !== mk(1'b1, 30 + i, 64)) begin
                    errors++; $display("FAIL ovf_drain[%0d]: got %0h want %0h", i, dut_acc[i], mk(1'b1, 30 + i, 64));
                end
            end
        end
        checks++; if (overflow !== 2'b01) begin errors++; $display("FAIL ovf_sticky: got %0b want 01", overflow); end
    endtask

    task automatic test_replay_burst();
        apply_reset();
        note_out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            replay = mk(1'b1, 40 + i, 90); replay_ready = 1'b1;
            tick();
        end
        idle_inputs();
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (dut_acc.size() != 8) begin
            errors++; $display("FAIL burst_count: got %0d want 8", dut_acc.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (dut_acc[i] !== mk(1'b1, 40 + i, 90)) begin
                    errors++; $display("FAIL burst_order[%0d]: got %0h want %0h", i, dut_acc[i], mk(1'b1, 40 + i, 90));
                end
            end
        end
        checks++; if (overflow !== 2'b00) begin errors++; $display("FAIL burst_overflow: got %0b want 00", overflow); end
    endtask

    task automatic test_random();
        int guard;
        apply_reset();
        for (int c = 0; c < 600; c++) begin
            live   = mk(1'($urandom_range(0, 1)), $urandom_range(0, 127), $urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 127));
            replay = mk(1'($urandom_range(0, 1)), $urandom_range(0, 127), $urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 127));
            live_ready     = ($urandom_range(0, 2) == 0);
            replay_ready   = ($urandom_range(0, 2) == 0);
            panic          = ($urandom_range(0, 249) == 0);
            note_out_ready = ($urandom_range(0, 3) != 0);
            tick();
            checks++; if (note_out_valid !== m_valid) begin errors++; $display("FAIL rand_valid@%0d: got %0b want %0b", c, note_out_valid, m_valid); end
            if (m_valid) begin
                checks++; if (note_out !== m_out) begin errors++; $display("FAIL rand_note@%0d: got %0h want %0h", c, note_out, m_out); end
            end
            checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL rand_overflow@%0d: got %0b want %0b", c, overflow, m_ovf); end
            checks++; if (busy !== model_busy()) begin errors++; $display("FAIL rand_busy@%0d: got %0b want %0b", c, busy, model_busy()); end
        end
        idle_inputs();
        note_out_ready = 1'b1;
        guard = 0;
        while ((busy || model_busy()) && guard < 400) begin tick(); guard++; end
        checks++; if (guard >= 400) begin errors++; $display("FAIL rand_drain_timeout: busy=%0b want 0", busy); end
        checks++;
        if (dut_acc.size() != m_acc.size()) begin
            errors++; $display("FAIL rand_acc_count: got %0d want %0d", dut_acc.size(), m_acc.size());
        end else begin
            for (int i = 0; i < m_acc.size(); i++) begin
                if (dut_acc[i] !== m_acc[i]) begin
                    errors++; $display("FAIL rand_acc[%0d]: got %0h want %0h", i, dut_acc[i], m_acc[i]);
                    break;
                end
            end
        end
    endtask

`ifdef NOTE_ARB_PANIC_EN
    task automatic test_panic();
        int base, guard;
        apply_reset();
        note_out_ready = 1'b1;
        live = mk(1'b1, 10, 100); live_ready = 1'b1; tick();
        live = mk(1'b1, 20, 100); tick();
        idle_inputs(); tick(); tick(); tick();
        base = dut_acc.size();
        panic = 1'b1; tick(); panic = 1'b0;
        tick(); tick();
        live = mk(1'b1, 77, 100); live_ready = 1'b1; tick(); live_ready = 1'b0;
        guard = 0;
        while (busy && guard < 300) begin tick(); guard++; end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL panic_busy_end: got %0b want 0", busy); end
        checks++;
        if (dut_acc.size() != base + 2) begin
            errors++; $display("FAIL panic_count: got %0d want %0d", dut_acc.size() - base, 2);
        end else begin
            checks++; if (dut_acc[base] !== mk(1'b0, 10, 0)) begin errors++; $display("FAIL panic_off10: got %0h want %0h", dut_acc[base], mk(1'b0, 10, 0)); end
            checks++; if (dut_acc[base+1] !== mk(1'b0, 20, 0)) begin errors++; $display("FAIL panic_off20: got %0h want %0h", dut_acc[base+1], mk(1'b0, 20, 0)); end
        end
        checks++; if (overflow !== 2'b00) begin errors++; $display("FAIL panic_overflow: got %0b want 00", overflow); end
    endtask
`endif

    task automatic test_reset_mid();
        apply_reset();
        note_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            live = mk(1'b1, 50 + i, 80); replay = mk(1'b1, 70 + i, 80);
            live_ready = 1'b1; replay_ready = 1'b1;
            tick();
        end
        idle_inputs();
        checks++; if (note_out_valid !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL midrst_loaded: v=%0b busy=%0b want 1 1", note_out_valid, busy); end
        #3 rst = 1'b1;
        #1;
        checks++; if (note_out_valid !== 1'b0 || note_out !== '0) begin errors++; $display("FAIL midrst_async: v=%0b out=%0h want 0 0", note_out_valid, note_out); end
        tick();
        rst = 1'b0;
        checks++; if (note_out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %0b want 0", note_out_valid); end
        checks++; if (note_out !== '0) begin errors++; $display("FAIL midrst_note: got %0h want 0", note_out); end
        checks++; if (overflow !== 2'b00) begin errors++; $display("FAIL midrst_overflow: got %0b want 00", overflow); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %0b want 0", busy); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_fifos_lost: busy=%0b want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_round_robin();
        test_overflow();
        test_replay_burst();
        test_random();
`ifdef NOTE_ARB_PANIC_EN
        test_panic();
`endif
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
